// File: rtl/osr_pull_if.sv
// Decoder / TX FIFO / OSR signal bundle around the OSR pull controller.
// slave = controller side, master = the surrounding state machine.
interface osr_pull_if;
  logic        penable, restart, autopull;
  logic [4:0]  pull_thresh;
  logic        out_valid;
  logic [4:0]  out_count;
  logic        pull_valid, pull_block, pull_ifempty;
  logic [31:0] x_in;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic [5:0]  shift_count, shift_count_lookahead;
  logic        fifo_pop, osr_set;
  logic [31:0] osr_din;
  logic        osr_do_shift;
  logic [4:0]  osr_shift;
  logic        stall, instr_done;

  modport slave (
    input  penable, restart, autopull, pull_thresh, out_valid, out_count,
           pull_valid, pull_block, pull_ifempty, x_in, fifo_empty, fifo_data,
           shift_count, shift_count_lookahead,
    output fifo_pop, osr_set, osr_din, osr_do_shift, osr_shift, stall, instr_done
  );
  modport master (
    output penable, restart, autopull, pull_thresh, out_valid, out_count,
           pull_valid, pull_block, pull_ifempty, x_in, fifo_empty, fifo_data,
           shift_count, shift_count_lookahead,
    input  fifo_pop, osr_set, osr_din, osr_do_shift, osr_shift, stall, instr_done
  );
endinterface

// File: rtl/osr_pull_ctrl.sv
// OSR sequencing for one PIO state machine: autopull, PULL variants and
// instruction stall generation. Only the state and stall counter are flops.
module osr_pull_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  osr_pull_if.slave              bus,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] STALL_OUT  = 2'd1;
  localparam logic [1:0] STALL_PULL = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]             thr;
  logic                   full, refill_la, have;
  logic                   pop, set, shift, stall, done;

  // A threshold field of 0 encodes 32, which is exactly bit 5 set.
  assign thr       = {(bus.pull_thresh == 5'd0), bus.pull_thresh};
  assign have      = !bus.fifo_empty;
  assign full      = bus.autopull && (bus.shift_count >= thr);
  assign refill_la = bus.autopull && (bus.shift_count_lookahead >= thr) && have;

  always_comb begin
    state_d = state_q;
    pop = 1'b0; set = 1'b0; shift = 1'b0; stall = 1'b0; done = 1'b0;
    if (bus.restart) begin
      state_d = RUN;
    end else if (bus.penable) begin
      case (state_q)
        STALL_OUT: begin
          if (!bus.out_valid) state_d = RUN;
          else begin
            stall = 1'b1;
            if (have) begin pop = 1'b1; set = 1'b1; state_d = RUN; end
          end
        end
        STALL_PULL: begin
          if (!bus.pull_valid) state_d = RUN;
          else if (!have) stall = 1'b1;
          else begin pop = 1'b1; set = 1'b1; done = 1'b1; state_d = RUN; end
        end
        default: begin
          if (bus.out_valid) begin
            if (full) begin
              stall = 1'b1;
              if (have) begin pop = 1'b1; set = 1'b1; end
              else state_d = STALL_OUT;
            end else begin
              shift = 1'b1; done = 1'b1;
              if (refill_la) begin pop = 1'b1; set = 1'b1; end
            end
          end else if (bus.pull_valid) begin
            if (bus.pull_ifempty && (bus.shift_count < thr)) done = 1'b1;
            else if (have) begin pop = 1'b1; set = 1'b1; done = 1'b1; end
            else if (bus.pull_block) begin stall = 1'b1; state_d = STALL_PULL; end
            else begin set = 1'b1; done = 1'b1; end
          end else if (full && have) begin
            pop = 1'b1; set = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.restart) cnt_d = '0;
    else if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything reads as zero while reset is held, without waiting for an edge.
  assign bus.fifo_pop     = reset_n & pop;
  assign bus.osr_set      = reset_n & set;
  assign bus.osr_do_shift = reset_n & shift;
  assign bus.stall        = reset_n & stall;
  assign bus.instr_done   = reset_n & done;
  assign bus.osr_din      = !reset_n ? 32'd0 : (pop ? bus.fifo_data : bus.x_in);
  assign bus.osr_shift    = reset_n ? bus.out_count : 5'd0;
  assign stall_cycles     = cnt_q;
endmodule

// File: tb/tb_osr_pull_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural model of the
// OSR pull rules; a second instance with a 4-bit counter covers saturation.
module tb_osr_pull_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [15:0] sc16;
  logic [3:0]  sc4;
  int checks = 0, failures = 0;

  osr_pull_if bus0();
  osr_pull_if bus1();

  osr_pull_ctrl #(.STALL_CNT_W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus0), .stall_cycles(sc16));
  osr_pull_ctrl #(.STALL_CNT_W(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus1), .stall_cycles(sc4));

  always #5 clk = ~clk;

  always_comb begin
    bus1.penable = bus0.penable;       bus1.restart = bus0.restart;
    bus1.autopull = bus0.autopull;     bus1.pull_thresh = bus0.pull_thresh;
    bus1.out_valid = bus0.out_valid;   bus1.out_count = bus0.out_count;
    bus1.pull_valid = bus0.pull_valid; bus1.pull_block = bus0.pull_block;
    bus1.pull_ifempty = bus0.pull_ifempty; bus1.x_in = bus0.x_in;
    bus1.fifo_empty = bus0.fifo_empty; bus1.fifo_data = bus0.fifo_data;
    bus1.shift_count = bus0.shift_count;
    bus1.shift_count_lookahead = bus0.shift_count_lookahead;
  end

  // {fifo_pop, osr_set, osr_do_shift, stall, instr_done}
  function automatic logic [4:0] strobes();
    return {bus0.fifo_pop, bus0.osr_set, bus0.osr_do_shift, bus0.stall, bus0.instr_done};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    bus0.penable = 1; bus0.restart = 0; bus0.autopull = 0; bus0.pull_thresh = 0;
    bus0.out_valid = 0; bus0.out_count = 0; bus0.pull_valid = 0; bus0.pull_block = 0;
    bus0.pull_ifempty = 0; bus0.x_in = 0; bus0.fifo_empty = 1; bus0.fifo_data = 0;
    bus0.shift_count = 6'd32; bus0.shift_count_lookahead = 6'd32;
  endtask

  task automatic do_restart();
    idle_inputs(); bus0.restart = 1; tick(); bus0.restart = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus0.autopull = 1; bus0.out_valid = 1; bus0.out_count = 5'd7; bus0.fifo_empty = 0;
    bus0.fifo_data = 32'h11112222; bus0.x_in = 32'h33334444; bus0.pull_valid = 1;
    #4;
    checks++; if (strobes() !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", strobes()); end
    checks++; if (bus0.osr_din !== 32'd0 || bus0.osr_shift !== 5'd0) begin failures++;
      $display("FAIL reset_data got din=%h shift=%0d exp 0/0", bus0.osr_din, bus0.osr_shift); end
    checks++; if (sc16 !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", sc16); end
    @(posedge clk); #1 reset_n = 1;
    idle_inputs(); tick();
  endtask

  task automatic test_autopull_refill();
    do_restart();
    bus0.autopull = 1; bus0.fifo_empty = 0; bus0.fifo_data = 32'hDEADBEEF;
    bus0.out_valid = 1; bus0.out_count = 5'd8;
    #4;
    checks++; if (strobes() !== 5'b11010 || bus0.osr_din !== 32'hDEADBEEF) begin failures++;
      $display("FAIL refill_c1 got=%b din=%h exp=11010 din=deadbeef", strobes(), bus0.osr_din); end
    tick();
    bus0.shift_count = 6'd0; bus0.shift_count_lookahead = 6'd8; bus0.fifo_empty = 1;
    #4;
    checks++; if (strobes() !== 5'b00101 || bus0.osr_shift !== 5'd8) begin failures++;
      $display("FAIL refill_c2 got=%b shift=%0d exp=00101 shift=8", strobes(), bus0.osr_shift); end
    checks++; if (sc16 !== 16'd1) begin failures++; $display("FAIL refill_cnt got=%0d exp=1", sc16); end
    tick(); idle_inputs();
  endtask

  task automatic test_shift_refill();
    do_restart();
    bus0.autopull = 1; bus0.pull_thresh = 5'd8; bus0.shift_count = 6'd0;
    bus0.shift_count_lookahead = 6'd8; bus0.fifo_empty = 0; bus0.fifo_data = 32'h0BADF00D;
    bus0.out_valid = 1; bus0.out_count = 5'd8;
    #4;
    checks++; if (strobes() !== 5'b11101 || bus0.osr_din !== 32'h0BADF00D) begin failures++;
      $display("FAIL shift_refill got=%b din=%h exp=11101 din=0badf00d", strobes(), bus0.osr_din); end
    tick(); idle_inputs();
  endtask

  task automatic test_empty_stall();
    do_restart();
    bus0.autopull = 1; bus0.out_valid = 1; bus0.out_count = 5'd8;
    for (int c = 1; c <= 5; c++) begin
      #4;
      checks++; if (strobes() !== 5'b00010) begin failures++;
        $display("FAIL empty_stall_c%0d got=%b exp=00010", c, strobes()); end
      tick();
    end
    bus0.fifo_empty = 0; bus0.fifo_data = 32'h12345678;
    #4;
    checks++; if (strobes() !== 5'b11010 || bus0.osr_din !== 32'h12345678) begin failures++;
      $display("FAIL empty_stall_pop got=%b din=%h exp=11010 din=12345678", strobes(), bus0.osr_din); end
    tick();
    bus0.fifo_empty = 1; bus0.shift_count = 6'd0; bus0.shift_count_lookahead = 6'd8;
    #4;
    checks++; if (strobes() !== 5'b00101 || sc16 !== 16'd6) begin failures++;
      $display("FAIL empty_stall_retire got=%b cnt=%0d exp=00101 cnt=6", strobes(), sc16); end
    tick(); idle_inputs();
  endtask

  task automatic test_pull_variants();
    do_restart();
    bus0.pull_valid = 1; bus0.x_in = 32'hA5A5A5A5;
    #4;
    checks++; if (strobes() !== 5'b01001 || bus0.osr_din !== 32'hA5A5A5A5) begin failures++;
      $display("FAIL pull_x got=%b din=%h exp=01001 din=a5a5a5a5", strobes(), bus0.osr_din); end
    tick();
    bus0.pull_block = 1;
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++; if (strobes() !== 5'b00010) begin failures++;
        $display("FAIL pull_block_c%0d got=%b exp=00010", c, strobes()); end
      tick();
    end
    bus0.fifo_empty = 0; bus0.fifo_data = 32'hC0FFEE00;
    #4;
    checks++; if (strobes() !== 5'b11001 || bus0.osr_din !== 32'hC0FFEE00) begin failures++;
      $display("FAIL pull_block_pop got=%b din=%h exp=11001 din=c0ffee00", strobes(), bus0.osr_din); end
    tick();
    bus0.pull_ifempty = 1; bus0.pull_thresh = 5'd16; bus0.shift_count = 6'd4;
    #4;
    checks++; if (strobes() !== 5'b00001) begin failures++;
      $display("FAIL pull_ifempty got=%b exp=00001", strobes()); end
    tick(); idle_inputs();
  endtask

  task automatic test_restart_reset();
    do_restart();
    bus0.pull_valid = 1; bus0.pull_block = 1;
    tick(); tick();
    bus0.restart = 1;
    #4;
    checks++; if (strobes() !== 5'b0) begin failures++;
      $display("FAIL restart_strobes got=%b exp=00000", strobes()); end
    tick();
    bus0.restart = 0; bus0.pull_valid = 0; bus0.out_valid = 1; bus0.out_count = 5'd3;
    #4;
    checks++; if (strobes() !== 5'b00101 || sc16 !== 16'd0) begin failures++;
      $display("FAIL restart_run got=%b cnt=%0d exp=00101 cnt=0", strobes(), sc16); end
    tick();
    bus0.out_valid = 0; bus0.pull_valid = 1;
    tick(); tick();
    #2 reset_n = 0;
    #1;
    checks++; if (bus0.stall !== 1'b0 || sc16 !== 16'd0) begin failures++;
      $display("FAIL async_reset got stall=%b cnt=%0d exp 0/0", bus0.stall, sc16); end
    #1 reset_n = 1;
    bus0.pull_valid = 0; bus0.out_valid = 1;
    #1;
    checks++; if (strobes() !== 5'b00101) begin failures++;
      $display("FAIL async_reset_run got=%b exp=00101", strobes()); end
    tick(); idle_inputs();
  endtask

  task automatic test_saturation();
    do_restart();
    bus0.autopull = 1; bus0.out_valid = 1;
    for (int c = 0; c < 23; c++) begin
      bus0.penable = !(c >= 10 && c < 13);
      if (!bus0.penable) begin
        #4;
        checks++; if (bus0.stall !== 1'b0) begin failures++;
          $display("FAIL penable_low_stall got=%b exp=0", bus0.stall); end
      end
      tick();
    end
    checks++; if (sc4 !== 4'd15 || sc16 !== 16'd20) begin failures++;
      $display("FAIL saturation got w4=%0d w16=%0d exp 15/20", sc4, sc16); end
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    bit wo = 0, wp = 0;
    int cnt = 0;
    logic [4:0]  e;
    logic [31:0] edin;
    int thr;
    bit full, have;
    do_restart();
    for (int i = 0; i < 600; i++) begin
      bus0.penable = ($urandom_range(0, 9) != 0);
      bus0.restart = ($urandom_range(0, 39) == 0);
      bus0.autopull = $urandom_range(0, 1);
      bus0.pull_thresh = $urandom_range(0, 31);
      bus0.out_valid = ($urandom_range(0, 9) < 4);
      bus0.out_count = $urandom_range(0, 31);
      bus0.pull_valid = ($urandom_range(0, 9) < 4);
      bus0.pull_block = $urandom_range(0, 1);
      bus0.pull_ifempty = $urandom_range(0, 1);
      bus0.x_in = $urandom; bus0.fifo_data = $urandom;
      bus0.fifo_empty = $urandom_range(0, 1);
      bus0.shift_count = $urandom_range(0, 32);
      bus0.shift_count_lookahead = $urandom_range(0, 32);
      thr  = (bus0.pull_thresh == 0) ? 32 : int'(bus0.pull_thresh);
      have = !bus0.fifo_empty;
      full = bus0.autopull && (int'(bus0.shift_count) >= thr);
      e = 5'b0;
      if (bus0.restart) begin wo = 0; wp = 0; end
      else if (bus0.penable) begin
        if (wo) begin
          if (!bus0.out_valid) wo = 0;
          else if (have) begin e = 5'b11010; wo = 0; end
          else e = 5'b00010;
        end else if (wp) begin
          if (!bus0.pull_valid) wp = 0;
          else if (have) begin e = 5'b11001; wp = 0; end
          else e = 5'b00010;
        end else if (bus0.out_valid) begin
          if (full) begin e = have ? 5'b11010 : 5'b00010; wo = !have; end
          else if (bus0.autopull && int'(bus0.shift_count_lookahead) >= thr && have) e = 5'b11101;
          else e = 5'b00101;
        end else if (bus0.pull_valid) begin
          if (bus0.pull_ifempty && int'(bus0.shift_count) < thr) e = 5'b00001;
          else if (have) e = 5'b11001;
          else if (bus0.pull_block) begin e = 5'b00010; wp = 1; end
          else e = 5'b01001;
        end else if (full && have) e = 5'b11000;
      end
      edin = e[4] ? bus0.fifo_data : bus0.x_in;
      #4;
      checks++; if (strobes() !== e || bus0.osr_din !== edin || bus0.osr_shift !== bus0.out_count) begin
        failures++;
        $display("FAIL rand_%0d got=%b din=%h sh=%0d exp=%b din=%h sh=%0d", i, strobes(),
                 bus0.osr_din, bus0.osr_shift, e, edin, bus0.out_count);
      end
      checks++; if (sc16 !== 16'(cnt) || sc4 !== 4'((cnt > 15) ? 15 : cnt)) begin failures++;
        $display("FAIL rand_cnt_%0d got=%0d/%0d exp=%0d", i, sc16, sc4, cnt); end
      tick();
      if (bus0.restart) cnt = 0;
      else if (e[1]) cnt = cnt + 1;
    end
    idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_autopull_refill();
    test_shift_refill();
    test_empty_stall();
    test_pull_variants();
    test_restart_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/osr_pull_ctrl.md
Name: osr_pull_ctrl

Overview:
- Sequences the PIO output shift register (OSR) for one state machine.
- Decides on each cycle whether the OSR loads from the TX FIFO or X, shifts for an OUT, or holds.
- Implements autopull, blocking/non-blocking PULL, PULL IFEMPTY, and instruction stall generation.
- Sits between the instruction decoder, the TX FIFO (show-ahead) and the OSR.

Parameters:
- STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- penable  input  1  state-machine clock enable; no action or state change when 0
- restart  input  1  synchronous state-machine restart
- autopull  input  1  autopull enable
- pull_thresh  input  5  pull threshold; 0 means 32
- out_valid  input  1  OUT instruction present this cycle
- out_count  input  5  OUT bit count; 0 means 32
- pull_valid  input  1  PULL instruction present this cycle
- pull_block  input  1  PULL block bit
- pull_ifempty  input  1  PULL IfEmpty bit
- x_in  input  32  scratch X value (non-blocking PULL on empty FIFO)
- fifo_empty  input  1  TX FIFO empty
- fifo_data  input  32  TX FIFO head (show-ahead)
- shift_count  input  6  OSR current count (32 = empty)
- shift_count_lookahead  input  6  OSR count after the in-flight shift
- fifo_pop  output  1  pop TX FIFO this cycle
- osr_set  output  1  load OSR from osr_din
- osr_din  output  32  fifo_data when popping, else x_in
- osr_do_shift  output  1  OSR shift this cycle
- osr_shift  output  5  equals out_count
- stall  output  1  instruction must be re-presented next cycle
- instr_done  output  1  OUT/PULL retired this cycle
- stall_cycles  output  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Threshold T = (pull_thresh==0) ? 32 : pull_thresh. Compare 6-bit unsigned.
- State register: RUN, STALL_OUT, STALL_PULL. All outputs are combinational from state and inputs; only state and stall_cycles are flops.
- Reset (reset_n low, async): state=RUN, stall_cycles=0. While in reset all outputs are 0.
- restart or penable=0: all strobes are 0 (fifo_pop, osr_set, osr_do_shift, stall, instr_done).
  - restart forces state=RUN and stall_cycles=0 on the clock edge.
  - penable=0 holds state and counter.
- out_valid and pull_valid both high: OUT is taken, PULL is ignored.
- RUN, out_valid:
  - If autopull and shift_count>=T:
    - FIFO not empty: fifo_pop=1, osr_set=1, stall=1, stay in RUN. The OUT executes on the next cycle.
    - FIFO empty: stall=1, go to STALL_OUT.
  - Otherwise: osr_do_shift=1, instr_done=1.
    - Additionally, if autopull, shift_count_lookahead>=T and FIFO not empty: fifo_pop=1 and osr_set=1 in the same cycle (shift-and-refill; count becomes 0).
- RUN, pull_valid:
  - If pull_ifempty and shift_count<T: instr_done=1, no pop (no-op).
  - Else if FIFO not empty: fifo_pop=1, osr_set=1, osr_din=fifo_data, instr_done=1.
  - Else if pull_block: stall=1, go to STALL_PULL.
  - Else: osr_set=1, osr_din=x_in, instr_done=1.
- RUN, idle (no instruction): if autopull, shift_count>=T and FIFO not empty, background refill (fifo_pop=1, osr_set=1).
- STALL_OUT:
  - stall=1 every cycle.
  - When FIFO not empty: pop and set, return to RUN; the OUT retires the following cycle.
  - If out_valid drops (decoder jumped), return to RUN without popping.
- STALL_PULL:
  - stall=1 until FIFO not empty.
  - Then: pop, set, instr_done=1, stall=0, return to RUN.
  - If pull_valid drops, return to RUN.
- stall_cycles increments on every cycle with stall=1 and penable=1, and saturates at all-ones.
- fifo_pop is never asserted when fifo_empty=1. osr_set and fifo_pop are asserted together, except for the non-blocking PULL of X.

Test Plan:
- Autopull refill: autopull=1, T=32, shift_count=32, FIFO holds 0xDEADBEEF, OUT 8 → cycle 1: pop+set+stall; cycle 2: do_shift, instr_done, stall_cycles=1.
- Shift-and-refill: T=8, shift_count=0, OUT 8, lookahead=8, FIFO non-empty → do_shift+osr_set+fifo_pop in one cycle, no stall.
- Empty FIFO stall: autopull, shift_count=32, FIFO empty for 5 cycles then 0x12345678 → STALL_OUT for 5 cycles, pop on cycle 6, OUT retires cycle 7, stall_cycles=6.
- PULL variants: empty FIFO with block=0 and x_in=0xA5A5A5A5 → osr_set with osr_din=0xA5A5A5A5, no pop. block=1 → stall until a push. IfEmpty with shift_count=4, T=16 → no-op retire.
- Restart during STALL_PULL → next cycle state RUN, stall=0, stall_cycles=0. Async reset_n pulse mid-stall clears immediately without a clock edge.
- Saturation: STALL_CNT_W=4, hold 20 stalled cycles → stall_cycles=15. penable=0 cycles do not increment.
